// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// ALU operation codes and the bundle of datapath control signals.
package mips_mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R,
      S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP, S_JAL_WB, S_ERR
   } state_t;

   // Which rule the ALU decoder applies in the current state.
   typedef enum logic [2:0] {
      CLS_NONE, CLS_ADD, CLS_SUB, CLS_R, CLS_I
   } alu_cls_t;

   localparam logic [5:0] OP_R     = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // The ALU consumes MIPS funct codes directly.
   localparam logic [5:0] ALU_NOP  = 6'h00;
   localparam logic [5:0] ALU_ADD  = 6'h20;
   localparam logic [5:0] ALU_ADDU = 6'h21;
   localparam logic [5:0] ALU_SUB  = 6'h22;
   localparam logic [5:0] ALU_AND  = 6'h24;
   localparam logic [5:0] ALU_OR   = 6'h25;
   localparam logic [5:0] ALU_SLT  = 6'h2A;

   typedef struct packed {
      logic       pc_wr;
      logic       pc_wr_cond;
      logic       br_ne;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_rd;
      logic       mem_wr;
      logic       ir_wr;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_wr;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       done;
   } ctrl_t;

endpackage

// File: rtl/mips_alu_dec.sv
// ALU operation decoder: picks the ALU op from the controller's state class,
// the opcode (I-type) or the funct field (R-type).
module mips_alu_dec
   import mips_mc_ctrl_pkg::*;
(
   input  logic [2:0] cls,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic [5:0] alu_op
);

   always_comb begin
      alu_op = ALU_NOP;
      case (alu_cls_t'(cls))
         CLS_ADD: alu_op = ALU_ADD;
         CLS_SUB: alu_op = ALU_SUB;
         CLS_R:   alu_op = funct;
         CLS_I: begin
            case (op)
               OP_ADDI:  alu_op = ALU_ADD;
               OP_ADDIU: alu_op = ALU_ADDU;
               OP_SLTI:  alu_op = ALU_SLT;
               OP_ANDI:  alu_op = ALU_AND;
               OP_ORI:   alu_op = ALU_OR;
               default:  alu_op = ALU_NOP;
            endcase
         end
         default: alu_op = ALU_NOP;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Main control FSM of the multi-cycle MIPS core, with a memory-stall watchdog
// that parks the controller in a sticky error state.
module mips_mc_ctrl
   import mips_mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 7
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   input  logic       z_i,
   input  logic       mem_rdy_i,
   output logic       pc_wr_o,
   output logic       pc_wr_cond_o,
   output logic       br_ne_o,
   output logic [1:0] pc_src_o,
   output logic       iord_o,
   output logic       mem_rd_o,
   output logic       mem_wr_o,
   output logic       ir_wr_o,
   output logic [1:0] reg_dst_o,
   output logic [1:0] mem_to_reg_o,
   output logic       reg_wr_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [5:0] alu_op_o,
   output logic       instr_done_o,
   output logic       err_o
);

   state_t           state, state_nx;
   logic [CNT_W-1:0] wdog, wdog_nx;
   logic             err;
   logic             wdog_hit;
   alu_cls_t         cls;
   logic [5:0]       alu_op;
   ctrl_t            c, co;
   logic             unused_z;

   // The branch condition is resolved in the datapath from br_ne_o and z_i.
   assign unused_z = z_i;
   assign wdog_hit = (wdog == CNT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_FETCH;
         wdog  <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         wdog  <= wdog_nx;
         if (state_nx == S_ERR) err <= 1'b1;
      end
   end

   // Watchdog only counts while a memory state holds; any transition clears it.
   always_comb begin
      state_nx = state;
      wdog_nx  = '0;
      c        = '0;
      cls      = CLS_NONE;
      case (state)
         S_FETCH: begin
            c.mem_rd    = 1'b1;
            c.alu_src_b = 2'b01;
            cls         = CLS_ADD;
            if (mem_rdy_i) begin
               c.ir_wr  = 1'b1;
               c.pc_wr  = 1'b1;
               state_nx = S_DECODE;
            end else if (wdog_hit) state_nx = S_ERR;
            else wdog_nx = wdog + CNT_W'(1);
         end
         S_DECODE: begin
            c.alu_src_b = 2'b11;
            cls         = CLS_ADD;
            case (op_i)
               OP_LW, OP_SW:                                 state_nx = S_MEM_ADDR;
               OP_R:                                         state_nx = S_EXEC_R;
               OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI:  state_nx = S_EXEC_I;
               OP_BEQ, OP_BNE:                               state_nx = S_BRANCH;
               OP_J:                                         state_nx = S_JUMP;
               OP_JAL:                                       state_nx = S_JAL_WB;
               default:                                      state_nx = S_ERR;
            endcase
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            cls         = CLS_ADD;
            state_nx    = (op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            c.iord   = 1'b1;
            c.mem_rd = 1'b1;
            if (mem_rdy_i) state_nx = S_MEM_WB;
            else if (wdog_hit) state_nx = S_ERR;
            else wdog_nx = wdog + CNT_W'(1);
         end
         S_MEM_WB: begin
            c.mem_to_reg = 2'b01;
            c.reg_wr     = 1'b1;
            c.done       = 1'b1;
            state_nx     = S_FETCH;
         end
         S_MEM_WR: begin
            c.iord   = 1'b1;
            c.mem_wr = 1'b1;
            if (mem_rdy_i) begin
               c.done   = 1'b1;
               state_nx = S_FETCH;
            end else if (wdog_hit) state_nx = S_ERR;
            else wdog_nx = wdog + CNT_W'(1);
         end
         S_EXEC_R: begin
            c.alu_src_a = 1'b1;
            cls         = CLS_R;
            state_nx    = S_R_WB;
         end
         S_R_WB: begin
            c.reg_dst = 2'b01;
            c.reg_wr  = 1'b1;
            c.done    = 1'b1;
            state_nx  = S_FETCH;
         end
         S_EXEC_I: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            cls         = CLS_I;
            state_nx    = S_I_WB;
         end
         S_I_WB: begin
            c.reg_wr = 1'b1;
            c.done   = 1'b1;
            state_nx = S_FETCH;
         end
         S_BRANCH: begin
            c.alu_src_a  = 1'b1;
            cls          = CLS_SUB;
            c.pc_wr_cond = 1'b1;
            c.pc_src     = 2'b01;
            c.br_ne      = (op_i == OP_BNE);
            c.done       = 1'b1;
            state_nx     = S_FETCH;
         end
         S_JUMP: begin
            c.pc_wr  = 1'b1;
            c.pc_src = 2'b10;
            c.done   = 1'b1;
            state_nx = S_FETCH;
         end
         S_JAL_WB: begin
            c.reg_dst    = 2'b10;
            c.mem_to_reg = 2'b10;
            c.reg_wr     = 1'b1;
            c.pc_wr      = 1'b1;
            c.pc_src     = 2'b10;
            c.done       = 1'b1;
            state_nx     = S_FETCH;
         end
         S_ERR:   state_nx = S_ERR;
         default: state_nx = S_ERR;
      endcase
   end

   mips_alu_dec u_alu_dec (
      .cls    (cls),
      .op     (op_i),
      .funct  (funct_i),
      .alu_op (alu_op)
   );

   // Gate with reset so an in-flight request or write drops the moment reset asserts.
   assign co           = reset ? c : '0;
   assign alu_op_o     = reset ? alu_op : '0;
   assign pc_wr_o      = co.pc_wr;
   assign pc_wr_cond_o = co.pc_wr_cond;
   assign br_ne_o      = co.br_ne;
   assign pc_src_o     = co.pc_src;
   assign iord_o       = co.iord;
   assign mem_rd_o     = co.mem_rd;
   assign mem_wr_o     = co.mem_wr;
   assign ir_wr_o      = co.ir_wr;
   assign reg_dst_o    = co.reg_dst;
   assign mem_to_reg_o = co.mem_to_reg;
   assign reg_wr_o     = co.reg_wr;
   assign alu_src_a_o  = co.alu_src_a;
   assign alu_src_b_o  = co.alu_src_b;
   assign instr_done_o = co.done;
   assign err_o        = err;

endmodule
